// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter in front of the external memory model.
// Write data stays locked to the granted owner until its single beat fires.
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 32
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif

module mem_arbiter (
    input  logic                           clk,
    input  logic                           reset,

    input  logic                           c0_req_valid,
    output logic                           c0_req_ready,
    input  logic                           c0_req_rw,
    input  logic [`MEM_ADDR_BITS-1:0]      c0_req_addr,
    input  logic [`MEM_TAG_BITS-2:0]       c0_req_tag,
    input  logic                           c0_req_data_valid,
    output logic                           c0_req_data_ready,
    input  logic [`MEM_DATA_BITS-1:0]      c0_req_data_bits,
    input  logic [`MEM_DATA_BITS/8-1:0]    c0_req_data_mask,
    output logic                           c0_resp_valid,
    output logic [`MEM_DATA_BITS-1:0]      c0_resp_data,
    output logic [`MEM_TAG_BITS-2:0]       c0_resp_tag,

    input  logic                           c1_req_valid,
    output logic                           c1_req_ready,
    input  logic                           c1_req_rw,
    input  logic [`MEM_ADDR_BITS-1:0]      c1_req_addr,
    input  logic [`MEM_TAG_BITS-2:0]       c1_req_tag,
    input  logic                           c1_req_data_valid,
    output logic                           c1_req_data_ready,
    input  logic [`MEM_DATA_BITS-1:0]      c1_req_data_bits,
    input  logic [`MEM_DATA_BITS/8-1:0]    c1_req_data_mask,
    output logic                           c1_resp_valid,
    output logic [`MEM_DATA_BITS-1:0]      c1_resp_data,
    output logic [`MEM_TAG_BITS-2:0]       c1_resp_tag,

    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic                           mem_req_rw,
    output logic [`MEM_ADDR_BITS-1:0]      mem_req_addr,
    output logic [`MEM_TAG_BITS-1:0]       mem_req_tag,
    output logic                           mem_req_data_valid,
    input  logic                           mem_req_data_ready,
    output logic [`MEM_DATA_BITS-1:0]      mem_req_data_bits,
    output logic [`MEM_DATA_BITS/8-1:0]    mem_req_data_mask,
    input  logic                           mem_resp_valid,
    input  logic [`MEM_DATA_BITS-1:0]      mem_resp_data,
    input  logic [`MEM_TAG_BITS-1:0]       mem_resp_tag
);

    localparam int AW = `MEM_ADDR_BITS;
    localparam int DW = `MEM_DATA_BITS;
    localparam int TW = `MEM_TAG_BITS;
    localparam int CT = TW - 1;
    localparam int MW = DW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WDATA = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_q, grant_d;
    logic   last_q,  last_d;

    logic          own_req_valid;
    logic          own_rw;
    logic [AW-1:0] own_addr;
    logic [CT-1:0] own_tag;
    logic          own_data_valid;
    logic [DW-1:0] own_data_bits;
    logic [MW-1:0] own_data_mask;

    logic req_fire;
    logic data_fire;

    // Owner view: everything below only looks at the granted client.
    always_comb begin
        own_req_valid  = grant_q ? c1_req_valid      : c0_req_valid;
        own_rw         = grant_q ? c1_req_rw         : c0_req_rw;
        own_addr       = grant_q ? c1_req_addr       : c0_req_addr;
        own_tag        = grant_q ? c1_req_tag        : c0_req_tag;
        own_data_valid = grant_q ? c1_req_data_valid : c0_req_data_valid;
        own_data_bits  = grant_q ? c1_req_data_bits  : c0_req_data_bits;
        own_data_mask  = grant_q ? c1_req_data_mask  : c0_req_data_mask;
    end

    assign req_fire  = (state_q == REQ)   && own_req_valid  && mem_req_ready;
    assign data_fire = (state_q == WDATA) && own_data_valid && mem_req_data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (c0_req_valid && c1_req_valid) begin
                    grant_d = ~last_q;
                    state_d = REQ;
                end else if (c0_req_valid || c1_req_valid) begin
                    grant_d = c1_req_valid;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (req_fire) begin
                    last_d  = grant_q;
                    state_d = own_rw ? WDATA : IDLE;
                end
            end
            WDATA: begin
                if (data_fire) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid      = 1'b0;
        mem_req_rw         = own_rw;
        mem_req_addr       = own_addr;
        mem_req_tag        = {grant_q, own_tag};
        mem_req_data_valid = 1'b0;
        mem_req_data_bits  = own_data_bits;
        mem_req_data_mask  = own_data_mask;
        c0_req_ready       = 1'b0;
        c1_req_ready       = 1'b0;
        c0_req_data_ready  = 1'b0;
        c1_req_data_ready  = 1'b0;
        unique case (state_q)
            IDLE: ;
            REQ: begin
                mem_req_valid = own_req_valid;
                c0_req_ready  = ~grant_q & mem_req_ready;
                c1_req_ready  =  grant_q & mem_req_ready;
            end
            WDATA: begin
                mem_req_data_valid = own_data_valid;
                c0_req_data_ready  = ~grant_q & mem_req_data_ready;
                c1_req_data_ready  =  grant_q & mem_req_data_ready;
            end
            default: ;
        endcase
    end

    // Responses bypass the FSM; the tag MSB names the issuing client.
    assign c0_resp_valid = mem_resp_valid & ~mem_resp_tag[TW-1];
    assign c1_resp_valid = mem_resp_valid &  mem_resp_tag[TW-1];
    assign c0_resp_tag   = mem_resp_tag[CT-1:0];
    assign c1_resp_tag   = mem_resp_tag[CT-1:0];
    assign c0_resp_data  = mem_resp_data;
    assign c1_resp_data  = mem_resp_data;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-client arbiter sitting directly upstream of the external memory model. It merges the instruction-cache refill port (client 0) and data-cache refill/writeback port (client 1) onto the single memory request/data/response interface. Grants are round-robin, and a granted write keeps the write-data channel locked to its owner until the data beat fires. Read responses are steered back to the issuing client by the tag MSB.

## Interface
Parameters:
- none. Widths are `MEM_ADDR_BITS`, `MEM_DATA_BITS` and `MEM_TAG_BITS` from util.vh.
- CT = `MEM_TAG_BITS`-1 is the client tag width.

Ports (N = 0, 1):
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cN_req_valid  in  1  client address request
- cN_req_ready  out  1  request accepted when valid&ready
- cN_req_rw  in  1  1 = write, 0 = read
- cN_req_addr  in  `MEM_ADDR_BITS`  address
- cN_req_tag  in  CT  client tag
- cN_req_data_valid  in  1  write-data beat valid
- cN_req_data_ready  out  1  write-data beat accepted
- cN_req_data_bits  in  `MEM_DATA_BITS`  write data
- cN_req_data_mask  in  `MEM_DATA_BITS`/8  byte mask
- cN_resp_valid  out  1  read response beat for client N
- cN_resp_data  out  `MEM_DATA_BITS`  response data (shared by both clients)
- cN_resp_tag  out  CT  client tag of the response
- mem_req_valid/ready/rw/addr/tag  out/in/out/out/out  1/1/1/`MEM_ADDR_BITS`/`MEM_TAG_BITS`  downstream request
- mem_req_data_valid/ready/bits/mask  out/in/out/out  1/1/`MEM_DATA_BITS`/`MEM_DATA_BITS`/8  downstream write data
- mem_resp_valid/data/tag  in/in/in  1/`MEM_DATA_BITS`/`MEM_TAG_BITS`  downstream response

## Operation
State machine has three states: IDLE, REQ, WDATA. It also holds a 1-bit `grant` register (owner) and a 1-bit `last` register (last winner).

IDLE:
- All ready and valid outputs to memory are 0.
- If exactly one cN_req_valid is high, set grant=N.
- If both are high, set grant=~last.
- If either is high, go to REQ.

REQ:
- mem_req_valid = c[grant]_req_valid.
- rw and addr come from the owner.
- mem_req_tag = {grant, c[grant]_req_tag}.
- c[grant]_req_ready = mem_req_ready; the other client's ready is 0.
- On fire: set last=grant. If rw=1, go to WDATA; otherwise go to IDLE.

WDATA:
- mem_req_data_valid/bits/mask come from the owner.
- c[grant]_req_data_ready = mem_req_data_ready.
- The other client's data_ready is 0.
- On data fire, go to IDLE.

Outside WDATA:
- Both cN_req_data_ready are 0.
- mem_req_data_valid is 0.

Response path is purely combinational and independent of the FSM:
- cN_resp_valid = mem_resp_valid & (mem_resp_tag[MSB]==N).
- cN_resp_tag = mem_resp_tag[CT-1:0].
- cN_resp_data = mem_resp_data.

Client rules:
- A client must hold valid and payload stable until fire.
- Dropping valid before fire is illegal; the arbiter need not handle it.

The arbiter does not track outstanding reads. The memory's own ready back-pressures any request issued during a read burst.

## Timing
- Reset value of every output: all ready and valid outputs are 0.
- Reset value of state: state=IDLE, grant=0, last=1, so client 0 wins the first tie.
- Reset mid-transaction aborts the transaction; the next cycle is IDLE with no outputs asserted.
- Arbitration latency: valid seen in IDLE at cycle t, mem_req_valid high at t+1. Fire at earliest t+1.
- Write data: earliest data fire is the cycle after the address fire. A single beat per write.
- Back-to-back: after a fire, the FSM returns to IDLE for one cycle. Minimum request spacing is therefore 2 cycles for a read and 3 for a write.
- Response path has zero-cycle latency; all 4 read beats are forwarded unchanged.
- Fairness: under continuous contention, grants strictly alternate 0,1,0,1,…
- A request arriving in a non-IDLE state waits. The grant decision is made only in IDLE; a higher-priority arrival never preempts the owner.

## Test plan
- Single read: c0 read, addr=0x40, tag=3 → mem_req_tag={0,3} at t+1. Memory returns 4 beats → c0_resp_valid high 4 cycles with tag 3; c1_resp_valid stays 0.
- Contention after reset: c0 and c1 both valid (reads) → c0 granted first and c1 second. With both held valid for 4 requests, the grant sequence is 0,1,0,1.
- Write lock: c1 write, addr=0x80, data=0xA5…, mask=0xFFFF. c0 asserts data_valid meanwhile → c0_req_data_ready stays 0. The memory sees c1's data with mask 0xFFFF, then the FSM returns to IDLE.
- Back-pressure: mem_req_ready held low 10 cycles in REQ → mem_req_valid and addr stay stable and the owner's ready stays 0. Fire occurs on the first ready cycle.
- Read during burst: c1 read is issued while c0's 4-beat response is in flight → c0 gets exactly 4 beats. c1's request fires only after the memory raises ready; its responses go to c1 only.
- Mid-op reset: reset asserted in WDATA → next cycle all ready and valid outputs are 0 and state is IDLE. After deassertion, contention grants c0 first.
